bram_snap_ctrl: RTL and testbench

Fabric-side snapshot capture controller that writes a qualified data stream into the fabric port of the team's wishbone-accessible dual-port BRAM (drives `fabric_we`, `fabric_addr`, `fabric_data_in`). Software arms it, a trigger starts the capture, and `done` flags a full buffer ready for wishbone readout. It runs entirely in the fabric clock domain.

---
 rtl/bram_snap_ctrl.sv | 170 +++++++++++++++++
 tb/tb_bram_snap_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_snap_ctrl.sv
// Snapshot capture into the fabric port of a dual-port BRAM; each accepted word is written one cycle after it arrives.
// No backpressure on the stream (one write per valid cycle); define SNAP_WRAP_EN for pre-trigger circular capture.
module bram_snap_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int POST_COUNT = 128
) (
  input  logic                  i_fabric_clk,
  input  logic                  i_fabric_rst,
  input  logic                  i_arm,
  input  logic                  i_trig,
  input  logic                  i_din_valid,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic                  o_bram_we,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic [DATA_WIDTH-1:0] o_bram_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_trig_addr,
  output logic [ADDR_WIDTH:0]   o_wr_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  if (POST_COUNT < 1 || POST_COUNT > DEPTH) begin : g_bad_post_count
    $error("bram_snap_ctrl: POST_COUNT must lie in 1..2**ADDR_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH:0]   r_wr_count;

  logic w_wr;
  logic w_post;
  logic w_last;

`ifdef SNAP_WRAP_EN
  localparam logic [ADDR_WIDTH:0] POST_CNT = (ADDR_WIDTH+1)'(POST_COUNT);

  logic [ADDR_WIDTH-1:0] r_trig_addr;
  logic [ADDR_WIDTH:0]   r_post_cnt;
  logic [ADDR_WIDTH:0]   w_post_nxt;

  assign w_post_nxt = r_post_cnt + 1'b1;
`endif

  // w_post marks a word that counts toward the post-trigger total (trigger word included).
  always_comb begin
    w_wr   = 1'b0;
    w_post = 1'b0;
    case (r_state)
      S_ARMED: begin
`ifdef SNAP_WRAP_EN
        w_wr   = i_din_valid;
`else
        w_wr   = i_din_valid && i_trig;
`endif
        w_post = i_trig;
      end
      S_CAPTURE: begin
        w_wr   = i_din_valid;
        w_post = 1'b1;
      end
      default: begin
        w_wr   = 1'b0;
        w_post = 1'b0;
      end
    endcase
`ifdef SNAP_WRAP_EN
    w_last = w_wr && w_post && (w_post_nxt == POST_CNT);
`else
    w_last = w_wr && (&r_ptr);
`endif
  end

  always_ff @(posedge i_fabric_clk) begin
    if (i_fabric_rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_count <= '0;
`ifdef SNAP_WRAP_EN
      r_trig_addr <= '0;
      r_post_cnt  <= '0;
`endif
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_addr <= r_ptr;
        r_data <= i_din;
        r_ptr  <= r_ptr + 1'b1;
        if (r_wr_count != DEPTH_CNT) begin
          r_wr_count <= r_wr_count + 1'b1;
        end
      end
`ifdef SNAP_WRAP_EN
      if (w_wr && w_post) begin
        r_post_cnt <= w_post_nxt;
      end
`endif

      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_arm) begin
            r_state    <= S_ARMED;
            r_ptr      <= '0;
            r_wr_count <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
`ifdef SNAP_WRAP_EN
            r_trig_addr <= '0;
            r_post_cnt  <= '0;
`endif
          end
        end
        S_ARMED: begin
          if (i_trig) begin
            r_state <= S_CAPTURE;
`ifdef SNAP_WRAP_EN
            r_trig_addr <= r_ptr;
`endif
          end
        end
        S_CAPTURE: begin
          r_state <= S_CAPTURE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Final word: done and busy flip on the same edge that presents the write.
      if (w_last) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  assign o_bram_we   = r_we;
  assign o_bram_addr = r_addr;
  assign o_bram_data = r_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_wr_count  = r_wr_count;
`ifdef SNAP_WRAP_EN
  assign o_trig_addr = r_trig_addr;
`else
  assign o_trig_addr = '0;
`endif

endmodule

// File: tb/tb_bram_snap_ctrl.sv
// Directed bench for bram_snap_ctrl at ADDR_WIDTH=4, POST_COUNT=4: vector table plus multi-cycle sequences.
module tb_bram_snap_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int PC = 4;

  logic          clk;
  logic          rst;
  logic          arm;
  logic          trig;
  logic          vld;
  logic [DW-1:0] din;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          busy;
  logic          done;
  logic [AW-1:0] taddr;
  logic [AW:0]   cnt;

  int checks;
  int failures;

  logic [DW-1:0] mem [16];

  bram_snap_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .POST_COUNT(PC)
  ) dut (
    .i_fabric_clk(clk),
    .i_fabric_rst(rst),
    .i_arm       (arm),
    .i_trig      (trig),
    .i_din_valid (vld),
    .i_din       (din),
    .o_bram_we   (we),
    .o_bram_addr (addr),
    .o_bram_data (data),
    .o_busy      (busy),
    .o_done      (done),
    .o_trig_addr (taddr),
    .o_wr_count  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          rst;
    logic          arm;
    logic          trig;
    logic          vld;
    logic [DW-1:0] din;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          busy;
    logic          done;
    logic [AW:0]   cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic a, input logic t, input logic v,
                              input logic [DW-1:0] d, input logic e_we, input int e_addr,
                              input logic [DW-1:0] e_data, input logic e_busy,
                              input logic e_done, input int e_cnt);
    vec_t x;
    x.rst  = r;
    x.arm  = a;
    x.trig = t;
    x.vld  = v;
    x.din  = d;
    x.we   = e_we;
    x.addr = AW'(e_addr);
    x.data = e_data;
    x.busy = e_busy;
    x.done = e_done;
    x.cnt  = (AW+1)'(e_cnt);
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
  task automatic drive(input logic r, input logic a, input logic t, input logic v,
                       input logic [DW-1:0] d);
    rst  = r;
    arm  = a;
    trig = t;
    vld  = v;
    din  = d;
    @(posedge clk);
    #1;
    if (we === 1'b1) mem[addr] = data;
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_we"},    32'(we),    32'd0);
    chk({tag, "_addr"},  32'(addr),  32'd0);
    chk({tag, "_data"},  data,       32'd0);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_done"},  32'(done),  32'd0);
    chk({tag, "_taddr"}, 32'(taddr), 32'd0);
    chk({tag, "_cnt"},   32'(cnt),   32'd0);
  endtask

  initial begin
    int   idx;
    int   cyc;
    logic fin;
    logic v;

    checks   = 0;
    failures = 0;
    rst = 1'b1; arm = 1'b0; trig = 1'b0; vld = 1'b0; din = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000;
    @(negedge clk);

`ifndef SNAP_WRAP_EN
    // rst arm trig vld din | we addr data busy done cnt
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h55, 0, 0, 32'h0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 32'h11, 0, 0, 32'h0,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h22, 0, 0, 32'h0,  1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'hA0, 1, 0, 32'hA0, 1, 0, 1));
    for (int k = 1; k < 16; k++) begin
      tbl.push_back(mk(0, 0, 0, 1, 32'hA0 + k, 1, k, 32'hA0 + k, (k < 15), (k == 15), k + 1));
    end
    tbl.push_back(mk(0, 0, 1, 1, 32'hEE, 0, 15, 32'hAF, 0, 1, 16));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,  0, 15, 32'hAF, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].arm, tbl[i].trig, tbl[i].vld, tbl[i].din);
      chk($sformatf("vec%0d_we", i),    32'(we),    32'(tbl[i].we));
      chk($sformatf("vec%0d_addr", i),  32'(addr),  32'(tbl[i].addr));
      chk($sformatf("vec%0d_data", i),  data,       tbl[i].data);
      chk($sformatf("vec%0d_busy", i),  32'(busy),  32'(tbl[i].busy));
      chk($sformatf("vec%0d_done", i),  32'(done),  32'(tbl[i].done));
      chk($sformatf("vec%0d_cnt", i),   32'(cnt),   32'(tbl[i].cnt));
      chk($sformatf("vec%0d_taddr", i), 32'(taddr), 32'd0);
    end
    for (int k = 0; k < 16; k++) chk($sformatf("fill_mem%0d", k), mem[k], 32'hA0 + k);

    // Valid gaps: 1,0,1,0 from the trigger cycle; 16 words take 31 cycles.
    idx = 0; cyc = 0; fin = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      v = (c % 2 == 0);
      drive(0, 0, (c == 0), v, 32'hB0 + c);
      cyc++;
      if (v) begin
        chk($sformatf("gap_we_c%0d", c),   32'(we),   32'd1);
        chk($sformatf("gap_addr_c%0d", c), 32'(addr), 32'(idx));
        idx++;
      end else begin
        chk($sformatf("gap_idle_we_c%0d", c), 32'(we), 32'd0);
      end
      if (done === 1'b1) fin = 1'b1;
    end
    chk("gap_done_seen", 32'(fin), 32'd1);
    chk("gap_cycles",    32'(cyc), 32'd31);
    chk("gap_words",     32'(idx), 32'd16);
    chk("gap_cnt",       32'(cnt), 32'd16);
    chk("gap_busy",      32'(busy), 32'd0);

    // arm pulsed mid-capture must not reset the pointer.
    drive(0, 1, 0, 0, 32'h0);
    chk("midarm_busy", 32'(busy), 32'd1);
    idx = -1; fin = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      drive(0, (c == 6), (c == 0), 1, 32'hC0 + c);
      chk($sformatf("midarm_addr_c%0d", c), 32'(addr), 32'(c));
      chk($sformatf("midarm_data_c%0d", c), data, 32'hC0 + c);
      if (done === 1'b1) begin
        fin = 1'b1;
        idx = c;
      end
    end
    chk("midarm_last_idx", 32'(idx), 32'd15);
    chk("midarm_cnt",      32'(cnt), 32'd16);

    // Reset after 5 writes, then restart from address 0.
    drive(0, 1, 0, 0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, (c == 0), 1, 32'hD0 + c);
      chk($sformatf("rstcap_addr_c%0d", c), 32'(addr), 32'(c));
    end
    chk("rstcap_cnt5", 32'(cnt), 32'd5);
    drive(1, 0, 0, 1, 32'hD5);
    chk_all_reset("midrst");
    drive(0, 0, 1, 1, 32'hD6);
    chk("postrst_idle_we",   32'(we),   32'd0);
    chk("postrst_idle_busy", 32'(busy), 32'd0);
    drive(0, 1, 0, 0, 32'h0);
    chk("rearm_busy", 32'(busy), 32'd1);
    drive(0, 0, 1, 1, 32'h77);
    chk("rearm_we",   32'(we),   32'd1);
    chk("rearm_addr", 32'(addr), 32'd0);
    chk("rearm_data", data,      32'h77);
    chk("rearm_cnt",  32'(cnt),  32'd1);
`else
    drive(1, 0, 0, 0, 32'h0);
    chk_all_reset("wrap_reset");
    drive(0, 1, 0, 0, 32'h0);
    chk("wrap_arm_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 1, 32'(i));
      chk($sformatf("wrap_pre_addr%0d", i), 32'(addr), 32'(i % 16));
      chk($sformatf("wrap_pre_cnt%0d", i),  32'(cnt),  32'((i + 1 > 16) ? 16 : i + 1));
    end
    drive(0, 0, 1, 1, 32'd20);
    chk("wrap_trig_addr", 32'(taddr), 32'd4);
    chk("wrap_trig_wa",   32'(addr),  32'd4);
    chk("wrap_trig_done", 32'(done),  32'd0);
    for (int i = 21; i < 24; i++) begin
      drive(0, 0, 0, 1, 32'(i));
      chk($sformatf("wrap_post_addr%0d", i), 32'(addr), 32'(i - 16));
      chk($sformatf("wrap_post_done%0d", i), 32'(done), 32'(i == 23));
      chk($sformatf("wrap_post_busy%0d", i), 32'(busy), 32'(i != 23));
    end
    drive(0, 0, 1, 1, 32'd99);
    chk("wrap_done_nowrite", 32'(we), 32'd0);
    chk("wrap_done_hold",    32'(done), 32'd1);
    chk("wrap_mem3", mem[3], 32'd19);
    chk("wrap_mem8", mem[8], 32'd8);
    for (int k = 4; k < 8; k++) chk($sformatf("wrap_mem%0d", k), mem[k], 32'(k + 16));
    drive(1, 0, 0, 0, 32'h0);
    chk_all_reset("wrap_final_reset");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
